// File: rtl/tpiu_frame_decoder.sv
// tpiu_frame_decoder: syncs TPIU frame toggles, demuxes ID/data bytes into a tagged valid/ready byte stream
module tpiu_frame_decoder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         PkAvail,
  input  logic [127:0] Packet,
  output logic         byteAvail,
  input  logic         byteReady,
  output logic [7:0]   byteOut,
  output logic [6:0]   streamId,
  output logic         frameOverflow
);
  typedef enum logic {IDLE, DECODE} state_t;
  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               dly_q;
  logic [127:0]       frame_q, frame_d;
  logic [3:0]         pos_q, pos_d;
  logic [6:0]         id_q, id_d, pend_q, pend_d;
  logic               pend_v_q, pend_v_d;
  logic               avail_q, avail_d, ovf_q, ovf_d;
  logic [7:0]         byte_q, byte_d;
  logic [6:0]         sid_q, sid_d;
  logic               new_frame, step, last, even, id_byte, aux, emit;
  logic [7:0]         cur, data;
  assign new_frame = sync_q[SYNC_STAGES-1] ^ dly_q;
  assign cur       = frame_q[{pos_q, 3'b000} +: 8];
  assign aux       = frame_q[{4'b1111, pos_q[3:1]}];
  assign even      = !pos_q[0];
  assign id_byte   = even && cur[0];
  assign data      = even ? {cur[7:1], aux} : cur;
  assign last      = pos_q == 4'd14;
  assign step      = state_q == DECODE && (!avail_q || byteReady);
  assign emit      = step && !id_byte && id_q != 7'h00 && id_q != 7'h7F;
  assign byteAvail     = avail_q;
  assign byteOut       = byte_q;
  assign streamId      = sid_q;
  assign frameOverflow = ovf_q;
  // toggle synchroniser plus one delay flop for edge detection
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PkAvail};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  // frame capture, one byte position per free output slot, ID tracking and output loading
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    pos_d    = pos_q;
    id_d     = id_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    avail_d  = avail_q && !byteReady;
    byte_d   = byte_q;
    sid_d    = sid_q;
    ovf_d    = new_frame && state_q == DECODE;
    if (state_q == IDLE && new_frame) begin
      frame_d = Packet;
      pos_d   = 4'd0;
      state_d = DECODE;
    end
    if (step) begin
      pos_d   = pos_q + 4'd1;
      state_d = last ? IDLE : DECODE;
      if (id_byte) begin
        if (!last && aux) begin
          pend_d   = cur[7:1];
          pend_v_d = 1'b1;
        end else begin
          id_d = cur[7:1];
        end
      end else if (pend_v_q) begin
        id_d     = pend_q;
        pend_v_d = 1'b0;
      end
      if (emit) begin
        avail_d = 1'b1;
        byte_d  = data;
        sid_d   = id_q;
      end
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      pos_q    <= '0;
      id_q     <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      avail_q  <= 1'b0;
      byte_q   <= '0;
      sid_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      pos_q    <= pos_d;
      id_q     <= id_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      avail_q  <= avail_d;
      byte_q   <= byte_d;
      sid_q    <= sid_d;
      ovf_q    <= ovf_d;
    end
endmodule

// File: tb/tb_tpiu_frame_decoder.sv
// tb_tpiu_frame_decoder: directed frames checked against a frame-level decode model
module tb_tpiu_frame_decoder;
  logic         clk = 1'b0;
  logic         rstn, PkAvail, byteReady, byteAvail, frameOverflow;
  logic [127:0] Packet;
  logic [7:0]   byteOut;
  logic [6:0]   streamId;
  always #5 clk = ~clk;
  tpiu_frame_decoder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .PkAvail(PkAvail), .Packet(Packet),
    .byteAvail(byteAvail), .byteReady(byteReady), .byteOut(byteOut),
    .streamId(streamId), .frameOverflow(frameOverflow)
  );
  int n_tests = 0, n_fail = 0;
  int cyc = 0, xfers = 0, ovf_cnt = 0, avail_cnt = 0;
  int x0, o0, a0, lat;
  int xfer_cyc[$];
  logic [14:0] exp_q[$];
  logic [14:0] e;
  logic [6:0]  model_id;
  logic [7:0]  fr[16];
  logic        prev_ovf = 1'b0, held_v = 1'b0;
  logic [7:0]  held_b;
  logic [6:0]  held_id;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic set_base(input logic [7:0] b0, input logic [7:0] b15);
    fr[0] = b0;
    for (int k = 1; k < 15; k++) fr[k] = 8'(2 * k);
    fr[15] = b15;
  endtask
  // expected output of one whole frame: effective ID per position, then filter
  task automatic model_frame();
    logic [6:0] cur, nxt;
    logic       a;
    logic [7:0] d;
    int         swap_at;
    cur = model_id;
    nxt = '0;
    swap_at = -1;
    for (int k = 0; k < 15; k++) begin
      a = fr[15][k/2];
      if (k % 2 == 0 && fr[k][0]) begin
        if (k < 14 && a) begin
          nxt = fr[k][7:1];
          swap_at = k + 1;
        end else cur = fr[k][7:1];
      end else begin
        d = (k % 2 == 1) ? fr[k] : {fr[k][7:1], a};
        if (cur != 7'h00 && cur != 7'h7F) exp_q.push_back({cur, d});
        if (k == swap_at) cur = nxt;
      end
    end
    model_id = cur;
  endtask
  task automatic send();
    for (int k = 0; k < 16; k++) Packet[8*k +: 8] = fr[k];
    model_frame();
    PkAvail = ~PkAvail;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rstn) begin
      held_v = 1'b0;
      prev_ovf = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_avail", byteAvail, 1);
        check("hold_byte", byteOut, held_b);
        check("hold_id", streamId, held_id);
      end
      if (byteAvail) avail_cnt++;
      if (byteAvail && byteReady) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got byte 0x%0h id 0x%0h, none expected", byteOut, streamId);
        end else begin
          e = exp_q.pop_front();
          check("byte", byteOut, e[7:0]);
          check("id", streamId, e[14:8]);
        end
        xfers++;
        xfer_cyc.push_back(cyc);
      end
      held_v = byteAvail && !byteReady;
      held_b = byteOut;
      held_id = streamId;
      if (frameOverflow) begin
        ovf_cnt++;
        check("ovf_single", prev_ovf, 0);
      end
      prev_ovf = frameOverflow;
    end
  end
  initial begin
    rstn = 1'b1; PkAvail = 1'b0; byteReady = 1'b1; Packet = '0; model_id = '0;
    #2 rstn = 1'b0;
    #1;
    check("rst_avail", byteAvail, 0);
    check("rst_byte", byteOut, 0);
    check("rst_id", streamId, 0);
    check("rst_ovf", frameOverflow, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle(2);
    // test 1: ID 3 then 14 data bytes back to back
    set_base(8'h07, 8'h00); x0 = xfers; send();
    check("model_t1_len", exp_q.size(), 14);
    check("model_t1_first", exp_q[0], {7'd3, 8'h02});
    check("model_t1_last", exp_q[13], {7'd3, 8'h1C});
    lat = 0;
    while (!byteAvail && lat < 20) begin @(posedge clk); #1; lat++; end
    check("t1_latency", lat, 5);
    idle(30);
    check("t1_drain", exp_q.size(), 0);
    check("t1_count", xfers - x0, 14);
    if (xfers - x0 == 14) check("t1_b2b", xfer_cyc[x0+13] - xfer_cyc[x0], 13);
    // test 2: aux bit sets LSB of the k=2 byte
    set_base(8'h07, 8'h02); send();
    check("model_t2_k2", exp_q[1], {7'd3, 8'h05});
    idle(30);
    check("t2_drain", exp_q.size(), 0);
    // test 3: ID 5 beforehand, delayed change to 3
    set_base(8'h0B, 8'h00); send(); idle(30);
    check("model_pre3_id", model_id, 5);
    set_base(8'h07, 8'h01); send();
    check("model_t3_first", exp_q[0], {7'd5, 8'h02});
    check("model_t3_second", exp_q[1], {7'd3, 8'h04});
    idle(30);
    check("t3_drain", exp_q.size(), 0);
    // test 4: ID 0 discards everything; next frame 16 cycles later accepted
    set_base(8'h01, 8'h00); a0 = avail_cnt; o0 = ovf_cnt; send();
    check("model_t4_len", exp_q.size(), 0);
    idle(16);
    check("t4_no_avail", avail_cnt - a0, 0);
    set_base(8'h07, 8'h00); x0 = xfers; send(); idle(30);
    check("t4_no_ovf", ovf_cnt - o0, 0);
    check("t4_second_count", xfers - x0, 14);
    check("t4_drain", exp_q.size(), 0);
    // test 5: backpressure with an overflowing toggle during the stall
    set_base(8'h07, 8'h00); x0 = xfers; o0 = ovf_cnt; send();
    lat = 0;
    while (!byteAvail && lat < 20) begin @(posedge clk); #1; lat++; end
    byteReady = 1'b0;
    idle(3);
    PkAvail = ~PkAvail;
    idle(7);
    check("t5_held_byte", byteOut, 8'h02);
    check("t5_held_id", streamId, 7'd3);
    byteReady = 1'b1;
    idle(40);
    check("t5_ovf", ovf_cnt - o0, 1);
    check("t5_count", xfers - x0, 14);
    check("t5_drain", exp_q.size(), 0);
    // test 6: reset after 5 bytes, then an ID-less frame is discarded
    set_base(8'h07, 8'h00); x0 = xfers; send();
    lat = 0;
    while (xfers - x0 < 5 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("t6_five_bytes", xfers - x0, 5);
    rstn = 1'b0; PkAvail = 1'b0;
    #1;
    check("t6_rst_avail", byteAvail, 0);
    check("t6_rst_id", streamId, 0);
    exp_q.delete();
    model_id = '0;
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(2);
    set_base(8'h02, 8'h00); a0 = avail_cnt; send();
    check("model_t6_len", exp_q.size(), 0);
    idle(30);
    check("t6_no_avail", avail_cnt - a0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
